// File: rtl/nc_sched_pkg.sv
// Shared types and width helpers for the NC memory scheduler.
package nc_sched_pkg;

  typedef enum logic [1:0] {
    FLUSH_IDLE  = 2'd0,
    FLUSH_DRAIN = 2'd1,
    FLUSH_ACK   = 2'd2
  } flush_state_e;

  function automatic int pcnt_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

  // A single requester still carries a 1-bit tag so the response path has a field to route on.
  function automatic int tid_width(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

endpackage

// File: rtl/nc_mem_scheduler_if.sv
// Handshake bundle between cache/NC requesters, the scheduler and the memory request port.
interface nc_mem_scheduler_if
  import nc_sched_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int MAX_PENDING = 8
) ();

  localparam int TID_W  = tid_width(NUM_REQS);
  localparam int PCNT_W = pcnt_width(MAX_PENDING);

  logic                cache_req_valid;
  logic                cache_req_ready;
  logic [NUM_REQS-1:0] nc_req_valid;
  logic [NUM_REQS-1:0] nc_req_rw;
  logic [NUM_REQS-1:0] nc_req_ready;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_req_sel_nc;
  logic [TID_W-1:0]    mem_req_nc_tid;
  logic                mem_rsp_nc_fire;
  logic                flush_req;
  logic                flush_ack;
  logic [PCNT_W-1:0]   nc_pending;

  modport master (
    output cache_req_valid, nc_req_valid, nc_req_rw, mem_req_ready, mem_rsp_nc_fire, flush_req,
    input  cache_req_ready, nc_req_ready, mem_req_valid, mem_req_sel_nc, mem_req_nc_tid,
           flush_ack, nc_pending
  );

  modport slave (
    input  cache_req_valid, nc_req_valid, nc_req_rw, mem_req_ready, mem_rsp_nc_fire, flush_req,
    output cache_req_ready, nc_req_ready, mem_req_valid, mem_req_sel_nc, mem_req_nc_tid,
           flush_ack, nc_pending
  );

endinterface

// File: rtl/nc_rr_picker.sv
// Round-robin picker: one-hot and index of the first request at or after the pointer.
module nc_rr_picker
  import nc_sched_pkg::*;
#(
  parameter int NUM_REQS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            req,
  input  logic                           fire,
  output logic [NUM_REQS-1:0]            pick,
  output logic [tid_width(NUM_REQS)-1:0] idx
);

  localparam int TID_W = tid_width(NUM_REQS);

  if (NUM_REQS == 1) begin : g_single
    logic unused_single;
    assign unused_single = &{1'b0, clk, reset, fire};
    assign pick = req;
    assign idx  = '0;
  end else begin : g_multi
    logic [TID_W-1:0] ptr;
    logic [TID_W-1:0] cand;

    // Walk from farthest to nearest so the closest request to the pointer is the last one written.
    always_comb begin
      pick = '0;
      idx  = '0;
      cand = '0;
      for (int off = NUM_REQS - 1; off >= 0; off--) begin
        cand = TID_W'((int'(ptr) + off) % NUM_REQS);
        if (req[cand]) begin
          pick       = '0;
          pick[cand] = 1'b1;
          idx        = cand;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ptr <= '0;
      end else if (fire) begin
        ptr <= (idx == TID_W'(NUM_REQS - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nc_mem_scheduler.sv
// Shares one memory request port between cache misses and round-robin NC requesters.
// Optional NC_SCHED_PERF_EN adds NC stall and starvation-override event counters.
module nc_mem_scheduler
  import nc_sched_pkg::*;
#(
  parameter int NUM_REQS     = 4,
  parameter int MAX_PENDING  = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  nc_mem_scheduler_if.slave bus
`ifdef NC_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_nc_stall_cycles,
  output logic [31:0]       perf_forced_grants
`endif
);

  localparam int PCNT_W   = pcnt_width(MAX_PENDING);
  localparam int TID_W    = tid_width(NUM_REQS);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [PCNT_W-1:0]   PEND_MAX   = PCNT_W'(MAX_PENDING);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  flush_state_e        state;
  logic                flush_ack_q;
  logic [PCNT_W-1:0]   pending;
  logic [PCNT_W-1:0]   pending_next;
  logic [STARVE_W-1:0] starve_cnt;
  logic [NUM_REQS-1:0] nc_eligible;
  logic [NUM_REQS-1:0] pick;
  logic [TID_W-1:0]    pick_idx;
  logic                read_ok;
  logic                cache_valid;
  logic                nc_any;
  logic                starved;
  logic                sel_nc;
  logic                fire;
  logic                nc_fire;
  logic                cache_fire;
  logic                nc_read_fire;
  logic                rsp_dec;

  // Requests are masked while reset is high so every output reads low during reset.
  assign read_ok     = (pending < PEND_MAX) && (state == FLUSH_IDLE);
  assign cache_valid = bus.cache_req_valid && !reset;
  assign nc_eligible = reset ? '0 : (bus.nc_req_valid & (bus.nc_req_rw | {NUM_REQS{read_ok}}));
  assign nc_any      = |nc_eligible;
  assign starved     = (starve_cnt == STARVE_MAX);
  assign sel_nc      = nc_any && (!cache_valid || starved);

  nc_rr_picker #(.NUM_REQS(NUM_REQS)) u_picker (
    .clk   (clk),
    .reset (reset),
    .req   (nc_eligible),
    .fire  (nc_fire),
    .pick  (pick),
    .idx   (pick_idx)
  );

  assign bus.mem_req_valid   = cache_valid || nc_any;
  assign bus.cache_req_ready = !reset && bus.mem_req_ready && !sel_nc;
  assign bus.nc_req_ready    = {NUM_REQS{bus.mem_req_ready && sel_nc}} & pick;
  assign bus.mem_req_sel_nc  = sel_nc;
  assign bus.mem_req_nc_tid  = sel_nc ? pick_idx : '0;
  assign bus.flush_ack       = flush_ack_q;
  assign bus.nc_pending      = pending;

  assign fire         = bus.mem_req_valid && bus.mem_req_ready;
  assign nc_fire      = fire && sel_nc;
  assign cache_fire   = fire && !sel_nc;
  assign nc_read_fire = nc_fire && ((pick & bus.nc_req_rw) == '0);
  assign rsp_dec      = bus.mem_rsp_nc_fire && (pending != '0);

  always_comb begin
    pending_next = pending;
    case ({nc_read_fire, rsp_dec})
      2'b10:   pending_next = pending + 1'b1;
      2'b01:   pending_next = pending - 1'b1;
      default: pending_next = pending;
    endcase
  end

  // Control state: credits, starvation count and the flush handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      starve_cnt  <= '0;
      state       <= FLUSH_IDLE;
      flush_ack_q <= 1'b0;
    end else begin
      pending <= pending_next;

      if (nc_fire || !nc_any) begin
        starve_cnt <= '0;
      end else if (cache_fire && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      case (state)
        FLUSH_IDLE: begin
          flush_ack_q <= 1'b0;
          if (bus.flush_req) state <= FLUSH_DRAIN;
        end
        FLUSH_DRAIN: begin
          if (pending_next == '0) begin
            state       <= FLUSH_ACK;
            flush_ack_q <= 1'b1;
          end
        end
        FLUSH_ACK: begin
          state       <= FLUSH_IDLE;
          flush_ack_q <= 1'b0;
        end
        default: begin
          state       <= FLUSH_IDLE;
          flush_ack_q <= 1'b0;
        end
      endcase
    end
  end

  a_rsp_underflow : assert property (@(posedge clk) disable iff (reset)
    !(bus.mem_rsp_nc_fire && (pending == '0)));

`ifdef NC_SCHED_PERF_EN
  logic forced_grant;
  assign forced_grant = nc_fire && cache_valid && starved;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_nc_stall_cycles <= '0;
      perf_forced_grants   <= '0;
    end else begin
      if ((|bus.nc_req_valid) && !nc_fire) perf_nc_stall_cycles <= perf_nc_stall_cycles + 32'd1;
      if (forced_grant) perf_forced_grants <= perf_forced_grants + 32'd1;
    end
  end
`endif

endmodule
